fabric_config_sequencer: RTL

FABRIC_CONFIG_SEQUENCER -- requirements
Module: fabric_config_sequencer

---
 rtl/fabric_config_pkg.sv | 26 ++
 rtl/config_timeout_counter.sv | 37 +++
 rtl/fabric_config_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fabric_config_pkg.sv
// Shared definitions for the fabric configuration sequencer.
// SLOT_W      : width of a configuration slot number.
// CNT_W       : width of the ack and timeout cycle counters.
// seq_state_e : sequencer states.
// in_load()   : true for states that belong to an active load attempt.
package fabric_config_pkg;

  localparam int SLOT_W = 4;
  localparam int CNT_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CHECK     = 3'd4,
    ST_RECV      = 3'd5,
    ST_FAIL      = 3'd6
  } seq_state_e;

  function automatic logic in_load(input seq_state_e s);
    return (s == ST_START) || (s == ST_WAIT_ACK) ||
           (s == ST_WAIT_DONE) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/config_timeout_counter.sv
// Saturating cycle counter used for the ack and load timeouts.
// clk, rst_n : clock, asynchronous active-low reset.
// load       : clears the count (wins over enable).
// enable     : advances the count by one, holding at LIMIT-1.
// expired    : the current cycle is the LIMIT-th enabled cycle since load,
//              so a caller acting on it leaves after exactly LIMIT cycles.
module config_timeout_counter
  import fabric_config_pkg::*;
#(
  parameter logic [CNT_W-1:0] LIMIT = 32'd16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = (LIMIT == '0) ? '0 : LIMIT - 32'd1;

  logic [CNT_W-1:0] count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (enable && (count_q < LAST)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign expired = (count_q >= LAST);

endmodule

// File: rtl/fabric_config_sequencer.sv
// Sequences fabric configuration loads through the SPI controller: boot load
// from slot 0, warmboot loads from a requested slot, one retry from
// FALLBACK_SLOT, and a passive receiver mode.
// mode_i            : 0 = SPI controller mode, 1 = SPI receiver mode.
// warmboot_req_i    : level request; rising edges start a load.
// warmboot_slot_i   : slot requested with the edge.
// ctrl_start_o      : one-cycle start pulse to the SPI controller.
// ctrl_slot_o       : slot for the controller, valid while ctrl_start_o=1.
// ctrl_busy_i       : SPI controller busy.
// cfg_busy_i        : fabric_config busy.
// cfg_configured_i  : fabric_config configured flag.
// fabric_hold_o     : keeps fabric user logic and WARMBOOT in reset.
// busy_o            : sequence in progress.
// error_o           : sticky load failure, cleared by a successful load.
// active_slot_o     : slot of the last started load.
module fabric_config_sequencer
  import fabric_config_pkg::*;
#(
  parameter logic [CNT_W-1:0]  TIMEOUT_CYCLES = 32'd1_000_000,
  parameter logic [CNT_W-1:0]  ACK_CYCLES     = 32'd16,
  parameter logic [SLOT_W-1:0] FALLBACK_SLOT  = 4'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_i,
  input  logic              warmboot_req_i,
  input  logic [SLOT_W-1:0] warmboot_slot_i,
  output logic              ctrl_start_o,
  output logic [SLOT_W-1:0] ctrl_slot_o,
  input  logic              ctrl_busy_i,
  input  logic              cfg_busy_i,
  input  logic              cfg_configured_i,
  output logic              fabric_hold_o,
  output logic              busy_o,
  output logic              error_o,
  output logic [SLOT_W-1:0] active_slot_o
);

  seq_state_e        state_q, state_d;
  logic              req_q;
  logic              boot_q;
  logic              retry_q, retry_d;
  logic              pend_q, pend_d;
  logic [SLOT_W-1:0] pend_slot_q, pend_slot_d;
  logic [SLOT_W-1:0] slot_d;
  logic              load_failed;
  logic              ack_expired, load_expired;
  logic              req_rise;

  assign req_rise = warmboot_req_i && !req_q;

  // Both counters restart in START; the load timer keeps running through
  // WAIT_ACK and WAIT_DONE so it measures time since the start pulse.
  config_timeout_counter #(.LIMIT(ACK_CYCLES)) u_ack_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state_q == ST_START),
    .enable  (state_q == ST_WAIT_ACK),
    .expired (ack_expired)
  );

  config_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_load_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state_q == ST_START),
    .enable  ((state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_DONE)),
    .expired (load_expired)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    state_d     = state_q;
    slot_d      = active_slot_o;
    retry_d     = retry_q;
    pend_d      = pend_q;
    pend_slot_d = pend_slot_q;
    load_failed = 1'b0;

    // A request arriving mid-load is remembered; a newer one replaces it.
    if (req_rise && in_load(state_q)) begin
      pend_d      = 1'b1;
      pend_slot_d = warmboot_slot_i;
    end

    case (state_q)
      ST_IDLE: begin
        if (mode_i) begin
          state_d = ST_RECV;
        end else if (boot_q || req_rise || pend_q) begin
          state_d = ST_START;
          retry_d = 1'b0;
          pend_d  = 1'b0;
          if (boot_q)        slot_d = '0;
          else if (req_rise) slot_d = warmboot_slot_i;
          else               slot_d = pend_slot_q;
        end
      end
      ST_START:     state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (ctrl_busy_i)                       state_d = ST_WAIT_DONE;
        else if (ack_expired || load_expired)  load_failed = 1'b1;
      end
      ST_WAIT_DONE: begin
        if (!ctrl_busy_i && !cfg_busy_i) state_d = ST_CHECK;
        else if (load_expired)           load_failed = 1'b1;
      end
      ST_CHECK: begin
        if (cfg_configured_i) state_d = ST_IDLE;
        else                  load_failed = 1'b1;
      end
      ST_RECV: begin
        if (!mode_i) state_d = ST_IDLE;
      end
      ST_FAIL: begin
        if (mode_i) begin
          state_d = ST_RECV;
        end else if (req_rise) begin
          state_d = ST_START;
          slot_d  = warmboot_slot_i;
          retry_d = 1'b0;
          pend_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_failed) begin
      if (retry_q) begin
        state_d = ST_FAIL;
      end else begin
        state_d = ST_START;
        slot_d  = FALLBACK_SLOT;
        retry_d = 1'b1;
      end
    end

    if (state_d == ST_RECV) pend_d = 1'b0;
  end

  // Outputs are registered from the next state so they line up with it.
  // The edge detector resets to 1 so a request held through reset is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      req_q         <= 1'b1;
      boot_q        <= 1'b1;
      retry_q       <= 1'b0;
      pend_q        <= 1'b0;
      pend_slot_q   <= '0;
      ctrl_start_o  <= 1'b0;
      fabric_hold_o <= 1'b1;
      busy_o        <= 1'b0;
      error_o       <= 1'b0;
      active_slot_o <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= warmboot_req_i;
      boot_q        <= 1'b0;
      retry_q       <= retry_d;
      pend_q        <= pend_d;
      pend_slot_q   <= pend_slot_d;
      ctrl_start_o  <= (state_d == ST_START);
      fabric_hold_o <= in_load(state_d) || (state_d == ST_FAIL) ||
                       ((state_d == ST_RECV) && cfg_busy_i);
      busy_o        <= in_load(state_d) || ((state_d == ST_RECV) && cfg_busy_i);
      if (state_d == ST_START) active_slot_o <= slot_d;
      if (state_d == ST_FAIL)                            error_o <= 1'b1;
      else if ((state_q == ST_CHECK) && cfg_configured_i) error_o <= 1'b0;
    end
  end

  assign ctrl_slot_o = ctrl_start_o ? active_slot_o : '0;

endmodule
